// File: rtl/dsi_ecc_pkg.sv
// Shared definitions for the DSI packet-header ECC checker: syndrome code table,
// parity/decode helpers and the header-assembly FSM states.
package dsi_ecc_pkg;

    localparam int DATA_W = 24;
    localparam int ECC_W  = 6;
    localparam logic [4:0] POS_NONE = 5'd31;

    // Syndrome code of each header data bit, entry 23 first.
    localparam logic [DATA_W-1:0][ECC_W-1:0] SYN_CODE = {
        6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
        6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
        6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
    };

    typedef struct packed {
        logic       fatal;
        logic       corr;
        logic [4:0] pos;
    } syn_res_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_CHK,
        ST_OUT
    } hdr_st_e;

    function automatic logic [ECC_W-1:0] ecc_calc(input logic [DATA_W-1:0] d);
        logic [ECC_W-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (d[i]) p = p ^ SYN_CODE[i];
        end
        return p;
    endfunction

    function automatic syn_res_t syn_decode(input logic [ECC_W-1:0] syn);
        syn_res_t r;
        r.fatal = 1'b0;
        r.corr  = 1'b0;
        r.pos   = POS_NONE;
        if (syn != '0) begin
            // A single set syndrome bit points at the ECC byte itself.
            if ((syn & (syn - 6'd1)) == '0) begin
                r.corr = 1'b1;
            end else begin
                r.fatal = 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (syn == SYN_CODE[i]) begin
                        r.fatal = 1'b0;
                        r.corr  = 1'b1;
                        r.pos   = 5'(i);
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dsi_hdr_syndrome.sv
// Combinational syndrome check of one assembled header: recomputes parity,
// decodes the syndrome and flips the single erroneous data bit if there is one.
module dsi_hdr_syndrome
    import dsi_ecc_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    input  logic [ECC_W-1:0]  ecc_i,
    output logic [DATA_W-1:0] d_o,
    output logic              corr_o,
    output logic              fatal_o,
    output logic [4:0]        pos_o
);

    logic [ECC_W-1:0]  syn;
    syn_res_t          res;
    logic [DATA_W-1:0] flip;

    always_comb begin
        syn = ecc_calc(d_i) ^ ecc_i;
        res = syn_decode(syn);
        flip = '0;
        for (int i = 0; i < DATA_W; i++) begin
            flip[i] = res.corr && (res.pos == 5'(i));
        end
    end

    assign d_o     = d_i ^ flip;
    assign corr_o  = res.corr;
    assign fatal_o = res.fatal;
    assign pos_o   = res.pos;

endmodule

// File: rtl/dsi_hdr_ecc_check.sv
// DSI RX packet-header ECC checker: assembles DI/WC/ECC bytes, corrects single-bit
// errors, flags fatal ones. Optional saturating counters under DSI_ECC_STATS_EN.
module dsi_hdr_ecc_check
    import dsi_ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_sop,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       m_di,
    output logic [15:0]      m_wc,
    output logic             m_corr,
    output logic             m_fatal,
    output logic [4:0]       m_err_pos,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_fatal
);

    hdr_st_e          state_q, state_d;
    logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [ECC_W-1:0] ecc_q, ecc_d;
    logic [7:0]       m_di_q, m_di_d;
    logic [15:0]      m_wc_q, m_wc_d;
    logic             m_corr_q, m_corr_d;
    logic             m_fatal_q, m_fatal_d;
    logic [4:0]       m_err_pos_q, m_err_pos_d;

    logic [DATA_W-1:0] d_cor;
    logic              syn_corr, syn_fatal;
    logic [4:0]        syn_pos;

    dsi_hdr_syndrome u_syn (
        .d_i     ({b2_q, b1_q, b0_q}),
        .ecc_i   (ecc_q),
        .d_o     (d_cor),
        .corr_o  (syn_corr),
        .fatal_o (syn_fatal),
        .pos_o   (syn_pos)
    );

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        ecc_d       = ecc_q;
        m_di_d      = m_di_q;
        m_wc_d      = m_wc_q;
        m_corr_d    = m_corr_q;
        m_fatal_d   = m_fatal_q;
        m_err_pos_d = m_err_pos_q;
        s_ready     = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && s_sop) begin
                    b0_d    = s_data;
                    state_d = ST_B1;
                end
            end
            ST_B1, ST_B2, ST_B3: begin
                if (s_valid) begin
                    // A fresh SOP mid-header resynchronises on the new packet.
                    if (s_sop) begin
                        b0_d    = s_data;
                        state_d = ST_B1;
                    end else begin
                        case (state_q)
                            ST_B1: begin
                                b1_d    = s_data;
                                state_d = ST_B2;
                            end
                            ST_B2: begin
                                b2_d    = s_data;
                                state_d = ST_B3;
                            end
                            default: begin
                                ecc_d   = s_data[ECC_W-1:0];
                                state_d = ST_CHK;
                            end
                        endcase
                    end
                end
            end
            ST_CHK: begin
                s_ready     = 1'b0;
                m_di_d      = d_cor[7:0];
                m_wc_d      = d_cor[23:8];
                m_corr_d    = syn_corr;
                m_fatal_d   = syn_fatal;
                m_err_pos_d = syn_pos;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                s_ready = 1'b0;
                if (m_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            ecc_q       <= '0;
            m_di_q      <= '0;
            m_wc_q      <= '0;
            m_corr_q    <= 1'b0;
            m_fatal_q   <= 1'b0;
            m_err_pos_q <= POS_NONE;
        end else begin
            state_q     <= state_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            ecc_q       <= ecc_d;
            m_di_q      <= m_di_d;
            m_wc_q      <= m_wc_d;
            m_corr_q    <= m_corr_d;
            m_fatal_q   <= m_fatal_d;
            m_err_pos_q <= m_err_pos_d;
        end
    end

    assign m_valid   = (state_q == ST_OUT);
    assign m_di      = m_di_q;
    assign m_wc      = m_wc_q;
    assign m_corr    = m_corr_q;
    assign m_fatal   = m_fatal_q;
    assign m_err_pos = m_err_pos_q;

`ifdef DSI_ECC_STATS_EN
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_fatal_q, cnt_fatal_d;
    logic             out_hs;

    assign out_hs = m_valid && m_ready;

    always_comb begin
        cnt_corr_d  = cnt_corr_q;
        cnt_fatal_d = cnt_fatal_q;
        if (cnt_clr) begin
            cnt_corr_d  = '0;
            cnt_fatal_d = '0;
        end else if (out_hs) begin
            if (m_corr_q && (cnt_corr_q != '1))   cnt_corr_d  = cnt_corr_q + 1'b1;
            if (m_fatal_q && (cnt_fatal_q != '1)) cnt_fatal_d = cnt_fatal_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_q  <= '0;
            cnt_fatal_q <= '0;
        end else begin
            cnt_corr_q  <= cnt_corr_d;
            cnt_fatal_q <= cnt_fatal_d;
        end
    end

    assign cnt_corr  = cnt_corr_q;
    assign cnt_fatal = cnt_fatal_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt_corr       = '0;
    assign cnt_fatal      = '0;
`endif

endmodule
